// File: rtl/counter_pkg.sv
// Shared definitions for the counter monitor: default width and FSM encoding.
package counter_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, clears on rst.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Next count: step only while below the saturation ceiling.
   always_comb begin
      q_d = q_q;
      if (inc && (q_q != '1)) begin
         q_d = q_q + W'(1);
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/counter_monitor.sv
// Cross-checks the arithmetic and gate-level counters, verifies +1 stepping,
// counts wrap-arounds and records the first fault.
module counter_monitor
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     cnt_a,
   input  logic [WIDTH-1:0]     cnt_g,
   output logic                 mismatch,
   output logic                 cmp_err,
   output logic                 seq_err,
   output logic [CNT_W-1:0]     wrap_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [2*WIDTH-1:0]   first_bad,
   output logic [STATE_W-1:0]   state
);

   state_e               state_q,     state_d;
   logic [WIDTH-1:0]     prev_a_q,    prev_a_d;
   logic                 mismatch_q,  mismatch_d;
   logic                 cmp_err_q,   cmp_err_d;
   logic                 seq_err_q,   seq_err_d;
   logic [2*WIDTH-1:0]   first_bad_q, first_bad_d;
   logic                 wrap_inc;
   logic                 err_inc;

   logic                 neq;
   logic                 step_ok;
   logic                 is_wrap;
   logic [WIDTH-1:0]     prev_next;

   assign neq       = (cnt_a != cnt_g);
   assign prev_next = prev_a_q + WIDTH'(1);
   assign step_ok   = (cnt_a == prev_next);
   assign is_wrap   = (prev_a_q == '1) && (cnt_a == '0);

   // Next-state, check and capture logic for the SYNC/TRACK/FAULT monitor.
   always_comb begin
      state_d     = state_q;
      prev_a_d    = prev_a_q;
      mismatch_d  = 1'b0;
      cmp_err_d   = cmp_err_q;
      seq_err_d   = seq_err_q;
      first_bad_d = first_bad_q;
      wrap_inc    = 1'b0;
      err_inc     = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if ((cnt_a == '0) && (cnt_g == '0)) begin
               state_d  = ST_TRACK;
               prev_a_d = cnt_a;
            end
         end
         ST_TRACK: begin
            mismatch_d = neq;
            err_inc    = neq;
            wrap_inc   = is_wrap;
            prev_a_d   = cnt_a;
            if (neq) begin
               cmp_err_d = 1'b1;
            end
            if (!step_ok) begin
               seq_err_d = 1'b1;
            end
            if (neq || !step_ok) begin
               first_bad_d = {cnt_a, cnt_g};
               state_d     = ST_FAULT;
            end
         end
         ST_FAULT: begin
            mismatch_d = neq;
            err_inc    = neq;
            if (neq) begin
               cmp_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   // State, history and sticky-flag registers; reset dominates every event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SYNC;
         prev_a_q    <= '0;
         mismatch_q  <= 1'b0;
         cmp_err_q   <= 1'b0;
         seq_err_q   <= 1'b0;
         first_bad_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_a_q    <= prev_a_d;
         mismatch_q  <= mismatch_d;
         cmp_err_q   <= cmp_err_d;
         seq_err_q   <= seq_err_d;
         first_bad_q <= first_bad_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_wrap_cnt (
      .clk (clk),
      .rst (rst),
      .inc (wrap_inc),
      .q   (wrap_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_inc),
      .q   (err_cnt)
   );

   assign mismatch  = mismatch_q;
   assign cmp_err   = cmp_err_q;
   assign seq_err   = seq_err_q;
   assign first_bad = first_bad_q;
   assign state     = state_q;

endmodule
